// File: rtl/busio_pkg.sv
// busio_pkg: shared types and defaults for the external bus I/O port.
// Register indices, bus FSM states and default widths/timeout.
package busio_pkg;

  typedef enum logic [1:0] {
    ADDR  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } reg_index;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } bus_state;

  localparam int DW_DEF      = 64;
  localparam int AW_DEF      = 20;
  localparam int TIMEOUT_DEF = 127;

endpackage

// File: rtl/busio_regfile.sv
// busio_regfile: four bus I/O registers, external + CPU write ports.
// External write wins when both target the same register.
module busio_regfile
  import busio_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ext_we,
  input  logic [1:0]    ext_sel,
  input  logic [DW-1:0] ext_d,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_sel,
  input  logic [DW-1:0] cpu_d,
  output logic [DW-1:0] cpu_q,
  input  logic [1:0]    bus_sel,
  output logic [DW-1:0] bus_q
);

  logic [DW-1:0] rg [4];

  // Register storage; the later external write overrides the CPU write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) rg[i] <= '0;
    end else begin
      if (cpu_we) rg[cpu_sel] <= cpu_d;
      if (ext_we) rg[ext_sel] <= ext_d;
    end
  end

  assign cpu_q = rg[cpu_sel];
  assign bus_q = rg[bus_sel];

endmodule

// File: rtl/busio_port.sv
// busio_port: executes arbiter strobes on the external memory bus.
// Optional parity on md_o/md_i is enabled by defining BUSIO_PARITY_EN.
module busio_port
  import busio_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] d_in,
  input  logic [1:0]    cpu_sel,
  input  logic          cpu_we,
  output logic [DW-1:0] d_out,
  input  logic [1:0]    arx,
  input  logic          ecx,
  input  logic          wrx,
  input  logic          astb,
  input  logic          rd,
  input  logic          wr,
  output logic          hold,
  output logic          berr,
  output logic [AW-1:0] ma,
  output logic [DW-1:0] md_o,
  output logic          md_oe,
  input  logic [DW-1:0] md_i,
  output logic          mem_astb,
  output logic          mem_rd,
  output logic          mem_wr,
`ifdef BUSIO_PARITY_EN
  output logic          md_par_o,
  input  logic          md_par_i,
  output logic          perr,
`endif
  input  logic          mem_rdy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  bus_state      state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] bus_q;
  logic          req;
  logic          tmo;
  logic          done;
  logic          astb_go;
  logic          ext_we;

  assign req     = (rd | wr) & ecx;
  assign tmo     = (cnt == CW'(TIMEOUT));
  assign done    = req & (mem_rdy | tmo);
  assign astb_go = astb & ecx & (arx == ADDR) & ~wrx;
  assign ext_we  = reset_n & rd & ecx & wrx & mem_rdy;

  // Read wins a rd/wr collision; reset kills all bus strobes at once.
  assign hold   = reset_n & req & ~mem_rdy & ~tmo;
  assign mem_rd = reset_n & rd & ecx;
  assign mem_wr = reset_n & wr & ecx & ~rd;
  assign md_oe  = ecx & ~wrx;
  assign md_o   = md_oe ? bus_q : '0;

  busio_regfile #(.DW(DW)) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .ext_we  (ext_we),
    .ext_sel (arx),
    .ext_d   (md_i),
    .cpu_we  (cpu_we),
    .cpu_sel (cpu_sel),
    .cpu_d   (d_in),
    .cpu_q   (d_out),
    .bus_sel (arx),
    .bus_q   (bus_q)
  );

  // Bus FSM: address latch, wait counter and sticky timeout error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ma       <= '0;
      mem_astb <= 1'b0;
      berr     <= 1'b0;
    end else begin
      mem_astb <= astb_go;
      if (astb_go) begin
        ma    <= bus_q[AW-1:0];
        berr  <= 1'b0;
        cnt   <= '0;
        state <= ACTIVE;
      end else if (done) begin
        cnt <= '0;
        if (!mem_rdy) berr <= 1'b1;
        if (state == ACTIVE) state <= IDLE;
      end else if (hold) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BUSIO_PARITY_EN
  assign md_par_o = ~^md_o;

  // Sticky parity error on external loads, cleared by the next address strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perr <= 1'b0;
    end else if (astb_go) begin
      perr <= 1'b0;
    end else if (ext_we && (md_par_i != ~^md_i)) begin
      perr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_busio_port.sv
// tb_busio_port: directed, table-driven bench for busio_port.
// Built with TIMEOUT=8 to keep the timeout sequence short.
module tb_busio_port;

  localparam int DW = 64;
  localparam int AW = 20;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] d_in;
  logic [1:0]    cpu_sel;
  logic          cpu_we;
  logic [DW-1:0] d_out;
  logic [1:0]    arx;
  logic          ecx, wrx, astb, rd, wr;
  logic          hold, berr;
  logic [AW-1:0] ma;
  logic [DW-1:0] md_o;
  logic          md_oe;
  logic [DW-1:0] md_i;
  logic          mem_astb, mem_rd, mem_wr, mem_rdy;
`ifdef BUSIO_PARITY_EN
  logic          md_par_o, md_par_i, perr, par_flip;
  assign md_par_i = (~^md_i) ^ par_flip;
`endif

  int checks;
  int failures;

  busio_port #(.DW(DW), .AW(AW), .TIMEOUT(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d_in     (d_in),
    .cpu_sel  (cpu_sel),
    .cpu_we   (cpu_we),
    .d_out    (d_out),
    .arx      (arx),
    .ecx      (ecx),
    .wrx      (wrx),
    .astb     (astb),
    .rd       (rd),
    .wr       (wr),
    .hold     (hold),
    .berr     (berr),
    .ma       (ma),
    .md_o     (md_o),
    .md_oe    (md_oe),
    .md_i     (md_i),
    .mem_astb (mem_astb),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
`ifdef BUSIO_PARITY_EN
    .md_par_o (md_par_o),
    .md_par_i (md_par_i),
    .perr     (perr),
`endif
    .mem_rdy  (mem_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ecx, wrx;
    logic [1:0]  arx;
    logic        rd, wr, rdy;
    logic        oe;
    logic [63:0] md;
    logic        mrd, mwr, hld;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rg_chk(input string nm, input logic [1:0] s,
                        input logic [63:0] exp);
    cpu_sel = s;
    #1;
    chk(nm, d_out, exp);
  endtask

  int n;

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; cpu_we = 1'b1; d_in = '1; cpu_sel = 2'd0;
    arx = 2'd0; ecx = 1'b0; wrx = 1'b0; astb = 1'b0;
    rd = 1'b0; wr = 1'b0; mem_rdy = 1'b0; md_i = '0;
`ifdef BUSIO_PARITY_EN
    par_flip = 1'b0;
`endif
    repeat (2) step();
    cpu_we = 1'b0;
    for (int i = 0; i < 4; i++) rg_chk("rst_rg", 2'(i), 64'd0);
    chk("rst_ma", 64'(ma), 64'd0);
    chk("rst_astb", 64'(mem_astb), 64'd0);
    chk("rst_rdwr", 64'({mem_rd, mem_wr}), 64'd0);
    chk("rst_hold", 64'(hold), 64'd0);
    chk("rst_berr", 64'(berr), 64'd0);
    reset_n = 1'b1;

    // CPU loads
    cpu_we = 1'b1;
    cpu_sel = 2'd0; d_in = 64'h01234; step();
    cpu_sel = 2'd2; d_in = 64'h5555555555555555; step();
    cpu_sel = 2'd1; d_in = 64'hC0DE; step();
    cpu_we = 1'b0;
    rg_chk("cpu_wr_rg0", 2'd0, 64'h01234);

    // Combinational drive / strobe table
    tbl[0] = '{1'b0,1'b0,2'd2,1'b0,1'b0,1'b0, 1'b0,64'h0,1'b0,1'b0,1'b0};
    tbl[1] = '{1'b1,1'b0,2'd2,1'b0,1'b0,1'b0,
               1'b1,64'h5555555555555555,1'b0,1'b0,1'b0};
    tbl[2] = '{1'b1,1'b0,2'd1,1'b0,1'b0,1'b0, 1'b1,64'hC0DE,1'b0,1'b0,1'b0};
    tbl[3] = '{1'b1,1'b1,2'd2,1'b0,1'b0,1'b0, 1'b0,64'h0,1'b0,1'b0,1'b0};
    tbl[4] = '{1'b1,1'b0,2'd2,1'b0,1'b1,1'b1,
               1'b1,64'h5555555555555555,1'b0,1'b1,1'b0};
    tbl[5] = '{1'b1,1'b0,2'd2,1'b0,1'b1,1'b0,
               1'b1,64'h5555555555555555,1'b0,1'b1,1'b1};
    tbl[6] = '{1'b1,1'b1,2'd3,1'b1,1'b1,1'b0, 1'b0,64'h0,1'b1,1'b0,1'b1};
    tbl[7] = '{1'b0,1'b1,2'd3,1'b1,1'b1,1'b0, 1'b0,64'h0,1'b0,1'b0,1'b0};
    tbl[8] = '{1'b1,1'b1,2'd3,1'b1,1'b0,1'b1, 1'b0,64'h0,1'b1,1'b0,1'b0};
    for (int i = 0; i < 9; i++) begin
      ecx = tbl[i].ecx; wrx = tbl[i].wrx; arx = tbl[i].arx;
      rd = tbl[i].rd; wr = tbl[i].wr; mem_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_oe", i), 64'(md_oe), 64'(tbl[i].oe));
      chk($sformatf("vec%0d_md", i), md_o, tbl[i].md);
      chk($sformatf("vec%0d_rd", i), 64'(mem_rd), 64'(tbl[i].mrd));
      chk($sformatf("vec%0d_wr", i), 64'(mem_wr), 64'(tbl[i].mwr));
      chk($sformatf("vec%0d_hold", i), 64'(hold), 64'(tbl[i].hld));
    end
    ecx = 1'b0; wrx = 1'b0; rd = 1'b0; wr = 1'b0; mem_rdy = 1'b0;
    step();

    // Zero-wait read
    astb = 1'b1; arx = 2'd0; ecx = 1'b1; wrx = 1'b0;
    step();
    astb = 1'b0;
    chk("zw_ma", 64'(ma), 64'h01234);
    chk("zw_astb1", 64'(mem_astb), 64'd1);
    rd = 1'b1; arx = 2'd3; wrx = 1'b1; mem_rdy = 1'b1;
    md_i = 64'hDEADBEEF00000001;
    #1;
    chk("zw_hold", 64'(hold), 64'd0);
    chk("zw_mrd", 64'(mem_rd), 64'd1);
    step();
    rd = 1'b0;
    chk("zw_astb0", 64'(mem_astb), 64'd0);
    rg_chk("zw_rg3", 2'd3, 64'hDEADBEEF00000001);

    // Wait-state read
    astb = 1'b1; arx = 2'd0; wrx = 1'b0;
    step();
    astb = 1'b0;
    rd = 1'b1; arx = 2'd3; wrx = 1'b1; mem_rdy = 1'b0;
    md_i = 64'h0A0B0C0D0E0F1011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ws_hold%0d", i), 64'(hold), 64'd1);
      chk($sformatf("ws_mrd%0d", i), 64'(mem_rd), 64'd1);
      step();
    end
    rg_chk("ws_rg3_keep", 2'd3, 64'hDEADBEEF00000001);
    mem_rdy = 1'b1;
    #1;
    chk("ws_hold_end", 64'(hold), 64'd0);
    step();
    rd = 1'b0; mem_rdy = 1'b0;
    rg_chk("ws_rg3", 2'd3, 64'h0A0B0C0D0E0F1011);

    // Timeout: rd in IDLE, counter must have restarted from 0
    rd = 1'b1; md_i = 64'hFFFF;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!hold) break;
      n++;
      step();
    end
    chk("to_holds", 64'(n), 64'd8);
    step();
    rd = 1'b0;
    chk("to_berr", 64'(berr), 64'd1);
    rg_chk("to_rg3", 2'd3, 64'h0A0B0C0D0E0F1011);
    chk("to_ma", 64'(ma), 64'h01234);
    astb = 1'b1; arx = 2'd0; wrx = 1'b0;
    step();
    astb = 1'b0;
    chk("to_berr_clr", 64'(berr), 64'd0);

    // Collision: external load beats CPU write
    ecx = 1'b1; wrx = 1'b1; arx = 2'd3; rd = 1'b1; mem_rdy = 1'b1;
    md_i = 64'h2; cpu_we = 1'b1; cpu_sel = 2'd3; d_in = 64'h1;
    step();
    cpu_we = 1'b0;
    rg_chk("col_rg3", 2'd3, 64'h2);
    md_i = 64'h7; cpu_we = 1'b1; cpu_sel = 2'd1; d_in = 64'h9;
    step();
    cpu_we = 1'b0;
    rg_chk("nocol_rg3", 2'd3, 64'h7);
    rg_chk("nocol_rg1", 2'd1, 64'h9);
`ifdef BUSIO_PARITY_EN
    chk("par_ok", 64'(perr), 64'd0);
    md_i = 64'h3; par_flip = 1'b1;
    step();
    par_flip = 1'b0; rd = 1'b0;
    chk("par_err", 64'(perr), 64'd1);
    rg_chk("par_rg3", 2'd3, 64'h3);
    astb = 1'b1; arx = 2'd0; wrx = 1'b0;
    step();
    astb = 1'b0;
    chk("par_clr", 64'(perr), 64'd0);
`endif

    // Reset in the middle of a wait-stated read
    rd = 1'b1; arx = 2'd3; wrx = 1'b1; mem_rdy = 1'b0;
    step();
    chk("mr_hold", 64'(hold), 64'd1);
    reset_n = 1'b0; mem_rdy = 1'b1; md_i = 64'hAB;
    #1;
    chk("mr_hold0", 64'(hold), 64'd0);
    chk("mr_mrd0", 64'(mem_rd), 64'd0);
    step();
    reset_n = 1'b1; rd = 1'b0; ecx = 1'b0;
    rg_chk("mr_rg3", 2'd3, 64'd0);
    chk("mr_ma", 64'(ma), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/busio_port.md
Name: busio_port

Overview:
- Downstream stage of the external bus arbiter: holds the four bus I/O registers RG0 ADDR, RG1 CMD, RG2 WDATA and RG3 RDATA.
- Executes the arbiter's arx/ecx/wrx/astb/rd/wr strobes against the external memory bus.
- Inserts wait states through `hold` while memory is not ready.
- Provides a CPU-side register window for microcode loads and reads.

Parameters:
- DW, 64: data word width.
- AW, 20: physical address width; taken from RG0[AW-1:0].
- TIMEOUT, 127: maximum wait cycles before a bus error.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- d_in  in  DW  internal data bus into the register window.
- cpu_sel  in  2  register index for CPU write and read.
- cpu_we  in  1  CPU write strobe.
- d_out  out  DW  RG[cpu_sel], combinational.
- arx  in  2  register index from the arbiter.
- ecx  in  1  port enable from the arbiter.
- wrx  in  1  1 = load the register from the external bus; 0 = drive the register onto the bus.
- astb  in  1  address strobe from the arbiter.
- rd  in  1  memory read request from the arbiter.
- wr  in  1  memory write request from the arbiter.
- hold  out  1  memory not ready; the arbiter freezes its step while high.
- berr  out  1  sticky timeout error.
- ma  out  AW  registered memory address.
- md_o  out  DW  external write data.
- md_oe  out  1  external data drive enable.
- md_i  in  DW  external read data.
- mem_astb  out  1  registered address strobe to memory.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdy  in  1  memory ready.

Behaviour:
- Reset values: RG0–RG3=0; ma=0; all strobes=0; hold=0; berr=0; wait counter=0; state IDLE.
- reset_n low mid-transaction aborts it immediately; no register load occurs.
- CPU write: cpu_we loads RG[cpu_sel] <= d_in on the clock edge.
- Bus drive: ecx & !wrx gives md_o=RG[arx], md_oe=1. Otherwise md_oe=0 and md_o=0.
- States: IDLE, ACTIVE.
- astb & ecx & arx==ADDR & !wrx, from any state:
  - ma <= RG0[AW-1:0];
  - mem_astb=1 for exactly the next cycle;
  - berr cleared;
  - wait counter cleared;
  - state goes to ACTIVE.
- ACTIVE:
  - mem_rd = rd & ecx; mem_wr = wr & ecx, both combinational.
  - hold = (rd|wr) & ecx & !mem_rdy & !tmo, combinational.
  - On each hold cycle the counter increments.
  - tmo = (counter == TIMEOUT).
- Completion: (rd|wr) & ecx & (mem_rdy | tmo). State returns to IDLE and the counter clears.
  - Read with mem_rdy and ecx & wrx: RG[arx] <= md_i.
  - Read with tmo: RG[arx] is unchanged and berr <= 1.
  - Write with tmo: berr <= 1.
- Latency: zero-wait memory (mem_rdy already high) completes in the same cycle as rd/wr, so hold never rises.
- rd or wr in IDLE (no preceding astb): uses the last latched ma and follows the same rules.
- rd and wr both high: protocol error. The read takes priority and mem_wr is forced to 0.
- Collision: an external load and cpu_we to the same register in the same cycle → the external value wins and the CPU write is dropped. Loads to different registers both take effect.
- ecx=0: no external load, no drive, hold=0.

Optional Feature:
- Macro: BUSIO_PARITY_EN.
- When defined, add three ports:
  - md_par_o out 1: odd parity of md_o.
  - md_par_i in 1: parity received with md_i.
  - perr out 1: sticky parity error.
- On every external load, a parity mismatch sets perr. The register is still loaded.
- perr resets to 0 and is cleared at the next astb.
- When not defined: none of these ports exist and there is no parity logic.

Decomposition:
- Package busio_pkg holds:
  - enum reg_index: ADDR=0, CMD=1, WDATA=2, RDATA=3;
  - enum bus_state: IDLE, ACTIVE;
  - default DW, AW and TIMEOUT constants.
- Sub-module busio_regfile: 4×DW registers with two write ports (external has priority over CPU), a combinational CPU read port and a combinational arbiter read port.

Test Plan:
- Reset: hold reset_n=0 for 2 clocks with cpu_we=1 → all registers, d_out, ma, strobes, hold and berr are 0.
- Zero-wait read:
  - CPU writes RG0=0x01234.
  - Cycle 1: astb, arx=ADDR, ecx=1 → next cycle ma=0x01234 and mem_astb=1 for 1 cycle.
  - Cycle 2: rd, arx=RDATA, wrx=1, mem_rdy=1, md_i=0xDEADBEEF00000001 → hold=0, RG3 loaded, d_out(cpu_sel=3) shows the value.
- Wait states: same read with mem_rdy low for 3 cycles → hold=1 and mem_rd=1 for 3 cycles, RG3 loads on the 4th cycle, counter returns to 0.
- Write: RG2=0x5555555555555555, arx=WDATA, ecx=1, wrx=0, wr=1, mem_rdy=1 → md_o=0x5555555555555555, md_oe=1, mem_wr=1, mem_rd=0.
- Timeout: TIMEOUT=8, mem_rdy never rises →
  - hold=1 for 8 cycles, then drops;
  - berr=1 and RG3 unchanged;
  - the next astb clears berr.
- Collision: cpu_we to RG3 with d_in=0x1 in the same cycle as an external load of 0x2 → RG3=0x2. With BUSIO_PARITY_EN, a flipped md_par_i sets perr=1.
